// File: rtl/clock_set_controller_pkg.sv
// Shared types and constants for the HH:MM time-setting controller.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  localparam logic [3:0] MASK_HOURS   = 4'b1100;
  localparam logic [3:0] MASK_MINUTES = 4'b0011;

  // Range-wrapping step: the result stays inside 0..max_v by comparison, never by modulo.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0)  ? max_v : v - 6'd1;
  endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Timekeeper/display-facing signal bundle of the time-setting controller.
interface clock_set_controller_if;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       pause;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [4:0] edit_hours;
  logic [5:0] edit_minutes;
  logic [3:0] blank_mask;

  modport master (
    input  cur_hours, cur_minutes,
    output pause, load, load_hours, load_minutes, edit_hours, edit_minutes, blank_mask
  );

  modport slave (
    output cur_hours, cur_minutes,
    input  pause, load, load_hours, load_minutes, edit_hours, edit_minutes, blank_mask
  );
endinterface

// File: rtl/clock_set_controller_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, one-cycle rising-edge pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q, level_q, pulse_q;
  logic [CW-1:0] cnt_q;

  // Any cycle where the synced input agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        pulse_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/clock_set_controller.sv
// Time-setting sequencer: debounced buttons drive an edit FSM that pauses the timekeeper,
// edits an HH:MM copy, commits it with a one-cycle load strobe and blinks the edited digits.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_HALF      = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_inc,
  input  logic btn_dec,
  clock_set_controller_if.master tk
);

  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);

  logic mode_p, inc_p, dec_p;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode
    (.clk(clk), .rst(rst), .btn_i(btn_mode), .pulse_o(mode_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc
    (.clk(clk), .rst(rst), .btn_i(btn_inc), .pulse_o(inc_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec
    (.clk(clk), .rst(rst), .btn_i(btn_dec), .pulse_o(dec_p));

  state_e        state_q, state_d;
  logic [4:0]    edit_h_q, edit_h_d, load_h_q, load_h_d;
  logic [5:0]    edit_m_q, edit_m_d, load_m_q, load_m_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic          pause_q, pause_d, load_q, load_d;
  logic [3:0]    blank_q, blank_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      edit_h_q <= '0;
      edit_m_q <= '0;
      load_h_q <= '0;
      load_m_q <= '0;
      idle_q   <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b0;
      pause_q  <= 1'b0;
      load_q   <= 1'b0;
      blank_q  <= '0;
    end else begin
      state_q  <= state_d;
      edit_h_q <= edit_h_d;
      edit_m_q <= edit_m_d;
      load_h_q <= load_h_d;
      load_m_q <= load_m_d;
      idle_q   <= idle_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      pause_q  <= pause_d;
      load_q   <= load_d;
      blank_q  <= blank_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    edit_h_d = edit_h_q;
    edit_m_d = edit_m_q;
    load_h_d = load_h_q;
    load_m_d = load_m_q;
    idle_d   = idle_q + IW'(1);
    blink_d  = blink_q + BW'(1);
    phase_d  = phase_q;
    if (blink_q == BW'(BLINK_HALF - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end

    case (state_q)
      ST_RUN: begin
        idle_d  = '0;
        blink_d = '0;
        phase_d = 1'b0;
        if (mode_p) begin
          state_d  = ST_SET_HR;
          edit_h_d = tk.cur_hours;
          edit_m_d = tk.cur_minutes;
        end
      end
      ST_SET_HR, ST_SET_MIN: begin
        // mode outranks both timeout and inc/dec; opposing inc+dec cancel out.
        if (mode_p) begin
          state_d = (state_q == ST_SET_HR) ? ST_SET_MIN : ST_COMMIT;
          idle_d  = '0;
          blink_d = '0;
          phase_d = 1'b0;
        end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          if (inc_p || dec_p) idle_d = '0;
          if (inc_p ^ dec_p) begin
            if (state_q == ST_SET_HR)
              edit_h_d = 5'(wrap_step({1'b0, edit_h_q}, {1'b0, MAX_HOUR}, inc_p));
            else
              edit_m_d = wrap_step(edit_m_q, MAX_MIN, inc_p);
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        idle_d  = '0;
        blink_d = '0;
        phase_d = 1'b0;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    pause_d = (state_d != ST_RUN);
    load_d  = (state_d == ST_COMMIT);
    if (load_d) begin
      load_h_d = edit_h_d;
      load_m_d = edit_m_d;
    end
    blank_d = '0;
    if (phase_d && state_d == ST_SET_HR)  blank_d = MASK_HOURS;
    if (phase_d && state_d == ST_SET_MIN) blank_d = MASK_MINUTES;
  end

  assign tk.pause        = pause_q;
  assign tk.load         = load_q;
  assign tk.load_hours   = load_h_q;
  assign tk.load_minutes = load_m_q;
  assign tk.edit_hours   = edit_h_q;
  assign tk.edit_minutes = edit_m_q;
  assign tk.blank_mask   = blank_q;

endmodule
